// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx -- transmit-side USB line encoder (full-speed line convention).
//
// Takes raw packet bits one per clock. It bit-stuffs and NRZI-encodes them onto
// dp/dm, then closes each packet with SE0 x EOP_SE0_CYCLES followed by one J.
//   J = (dp=1, dm=0), K = (dp=0, dm=1), SE0 = (0, 0).
//
// Compile-time option: USB_NRZI_TX_STUFF_EN
//   defined   -> a 0 is stuffed after STUFF_LEN consecutive 1s.
//   undefined -> no stuffing; the STUFF state, ones counter and STUFF_LEN are absent.
//
// Ports:
//   clk           in   bit-rate clock
//   rst           in   asynchronous, active-high reset
//   bstr_in       in   raw data bit
//   bstr_in_ready in   bstr_in is valid
//   in_done       in   current bit is the last bit of the packet
//   bstr_in_take  out  bit accepted when high together with bstr_in_ready (combinational)
//   dp, dm        out  registered line levels
//   tx_oe         out  registered pad output enable
//   out_done      out  one-cycle pulse, coincident with the EOP J on the line
//   tx_err        out  one-cycle pulse on underrun abort
module usb_nrzi_tx #(
`ifdef USB_NRZI_TX_STUFF_EN
   parameter int unsigned STUFF_LEN      = 6,
`endif
   parameter int unsigned EOP_SE0_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic bstr_in,
   input  logic bstr_in_ready,
   input  logic in_done,
   output logic bstr_in_take,
   output logic dp,
   output logic dm,
   output logic tx_oe,
   output logic out_done,
   output logic tx_err
);

   localparam int unsigned     SeW    = $clog2(EOP_SE0_CYCLES + 1);
   localparam logic [SeW-1:0]  SeLoad = SeW'(EOP_SE0_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StData,
`ifdef USB_NRZI_TX_STUFF_EN
      StStuff,
`endif
      StEopSe0,
      StEopJ
   } state_t;

   state_t         r_state;
   logic           r_lvl;      // last NRZI level, 1 = J
   logic [SeW-1:0] r_se0_cnt;  // remaining SE0 cycles minus one
   logic           w_accept;
   logic           w_lvl_acc;  // level after encoding the offered bit

   assign bstr_in_take = ~rst & ((r_state == StIdle) | (r_state == StData));
   assign w_accept     = bstr_in_take & bstr_in_ready;
   assign w_lvl_acc    = bstr_in ? r_lvl : ~r_lvl;

`ifdef USB_NRZI_TX_STUFF_EN
   localparam int unsigned       OnesW   = $clog2(STUFF_LEN + 1);
   localparam logic [OnesW-1:0]  OnesMax = OnesW'(STUFF_LEN);

   logic [OnesW-1:0] r_ones;
   logic             r_last;      // stuffed bit follows the last packet bit
   logic [OnesW-1:0] w_ones_acc;
   logic             w_stuff_due;

   // A packet always starts counting from zero, whatever the previous one left.
   assign w_ones_acc  = !bstr_in ? '0 :
                        (r_state == StIdle) ? OnesW'(1) : r_ones + 1'b1;
   assign w_stuff_due = (w_ones_acc == OnesMax);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_lvl     <= 1'b1;
         r_se0_cnt <= '0;
         dp        <= 1'b1;
         dm        <= 1'b0;
         tx_oe     <= 1'b0;
         out_done  <= 1'b0;
         tx_err    <= 1'b0;
`ifdef USB_NRZI_TX_STUFF_EN
         r_ones    <= '0;
         r_last    <= 1'b0;
`endif
      end else begin
         out_done <= 1'b0;
         tx_err   <= 1'b0;
         unique case (r_state)
            StIdle, StData: begin
               if (w_accept) begin
                  r_lvl <= w_lvl_acc;
                  dp    <= w_lvl_acc;
                  dm    <= ~w_lvl_acc;
                  tx_oe <= 1'b1;
`ifdef USB_NRZI_TX_STUFF_EN
                  r_ones <= w_ones_acc;
                  r_last <= in_done;
                  // A pending stuff goes out before the EOP.
                  if (w_stuff_due) begin
                     r_state <= StStuff;
                  end else if (in_done) begin
`else
                  if (in_done) begin
`endif
                     r_state   <= StEopSe0;
                     r_se0_cnt <= SeLoad;
                  end else begin
                     r_state <= StData;
                  end
               end else if (r_state == StData) begin
                  // Underrun: truncate the packet; the line holds its level for one cycle.
                  tx_err    <= 1'b1;
                  r_state   <= StEopSe0;
                  r_se0_cnt <= SeLoad;
`ifdef USB_NRZI_TX_STUFF_EN
                  r_ones    <= '0;
`endif
               end else begin
                  tx_oe <= 1'b0;
               end
            end
`ifdef USB_NRZI_TX_STUFF_EN
            StStuff: begin
               r_lvl  <= ~r_lvl;
               dp     <= ~r_lvl;
               dm     <= r_lvl;
               r_ones <= '0;
               if (r_last) begin
                  r_state   <= StEopSe0;
                  r_se0_cnt <= SeLoad;
               end else begin
                  r_state <= StData;
               end
            end
`endif
            StEopSe0: begin
               dp <= 1'b0;
               dm <= 1'b0;
               if (r_se0_cnt == '0) begin
                  r_state <= StEopJ;
               end else begin
                  r_se0_cnt <= r_se0_cnt - 1'b1;
               end
            end
            StEopJ: begin
               dp       <= 1'b1;
               dm       <= 1'b0;
               r_lvl    <= 1'b1;
               out_done <= 1'b1;
               r_state  <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Bench for usb_nrzi_tx. Each stimulus cycle pushes its hand-computed expected
// outputs into a scoreboard queue; a monitor pops and compares at the falling edge.
module tb_usb_nrzi_tx;

   localparam logic [1:0] J = 2'b10;
   localparam logic [1:0] K = 2'b01;
   localparam logic [1:0] S = 2'b00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bstr_in = 1'b0;
   logic bstr_in_ready = 1'b0;
   logic in_done = 1'b0;
   logic bstr_in_take, dp, dm, tx_oe, out_done, tx_err;

   usb_nrzi_tx dut (
      .clk          (clk),
      .rst          (rst),
      .bstr_in      (bstr_in),
      .bstr_in_ready(bstr_in_ready),
      .in_done      (in_done),
      .bstr_in_take (bstr_in_take),
      .dp           (dp),
      .dm           (dm),
      .tx_oe        (tx_oe),
      .out_done     (out_done),
      .tx_err       (tx_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int         tid;
      int         cyc;
      logic [5:0] exp;  // {take, dp, dm, oe, done, err}
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   tid = 0;
   int   cyc = 0;

   // Monitor: one scoreboard entry per cycle.
   always @(negedge clk) begin
      exp_t       e;
      logic [5:0] got;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         got = {bstr_in_take, dp, dm, tx_oe, out_done, tx_err};
         n_vec++;
         if (got !== e.exp) begin
            n_bad++;
            $display("FAIL t%0d.c%0d take/dp/dm/oe/done/err: got %b want %b",
                     e.tid, e.cyc, got, e.exp);
         end
      end
   end

   task automatic start(input int id);
      tid = id;
      cyc = 0;
   endtask

   task automatic cy(input logic r, input logic b, input logic d, input logic tk,
                     input logic [1:0] ln, input logic oe, input logic od, input logic er);
      exp_t e;
      bstr_in_ready = r;
      bstr_in       = b;
      in_done       = d;
      e.tid = tid;
      e.cyc = cyc;
      e.exp = {tk, ln, oe, od, er};
      sb.push_back(e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // EOP tail starting with the first SE0 cycle on the line.
   task automatic eop_tail();
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(0, 0, 0, 1, J, 1, 1, 0);
      cy(0, 0, 0, 1, J, 0, 0, 0);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset values while rst is high.
      start(0);
      cy(0, 0, 0, 0, J, 0, 0, 0);
      cy(1, 1, 1, 0, J, 0, 0, 0);
      rst = 1'b0;

      // SYNC pattern.
      start(1);
      cy(1, 0, 0, 1, J, 0, 0, 0);
      cy(1, 0, 0, 1, K, 1, 0, 0);
      cy(1, 0, 0, 1, J, 1, 0, 0);
      cy(1, 0, 0, 1, K, 1, 0, 0);
      cy(1, 0, 0, 1, J, 1, 0, 0);
      cy(1, 0, 0, 1, K, 1, 0, 0);
      cy(1, 0, 0, 1, J, 1, 0, 0);
      cy(1, 1, 1, 1, K, 1, 0, 0);
      cy(0, 0, 0, 0, K, 1, 0, 0);
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(0, 0, 0, 1, J, 1, 1, 0);
      cy(0, 0, 1, 1, J, 0, 0, 0);  // in_done ignored without ready

      // One 0 then eight 1s.
      start(2);
      cy(1, 0, 0, 1, J, 0, 0, 0);
`ifdef USB_NRZI_TX_STUFF_EN
      for (int i = 0; i < 6; i++) cy(1, 1, 0, 1, K, 1, 0, 0);
      cy(1, 1, 0, 0, K, 1, 0, 0);  // stuff cycle, bit held
      cy(1, 1, 0, 1, J, 1, 0, 0);
      cy(1, 1, 1, 1, J, 1, 0, 0);
      cy(0, 0, 0, 0, J, 1, 0, 0);
`else
      for (int i = 0; i < 7; i++) cy(1, 1, 0, 1, K, 1, 0, 0);
      cy(1, 1, 1, 1, K, 1, 0, 0);
      cy(0, 0, 0, 0, K, 1, 0, 0);
`endif
      eop_tail();

      // Six 1s, last bit on the sixth.
      start(3);
      cy(1, 1, 0, 1, J, 0, 0, 0);
      for (int i = 0; i < 4; i++) cy(1, 1, 0, 1, J, 1, 0, 0);
      cy(1, 1, 1, 1, J, 1, 0, 0);
      cy(0, 0, 0, 0, J, 1, 0, 0);
`ifdef USB_NRZI_TX_STUFF_EN
      cy(0, 0, 0, 0, K, 1, 0, 0);  // stuffed bit before SE0
`endif
      eop_tail();

      // Underrun after three bits.
      start(4);
      cy(1, 1, 0, 1, J, 0, 0, 0);
      cy(1, 0, 0, 1, J, 1, 0, 0);
      cy(1, 0, 0, 1, K, 1, 0, 0);
      cy(0, 1, 1, 1, J, 1, 0, 0);
      cy(0, 0, 0, 0, J, 1, 0, 1);
      eop_tail();

      // Reset mid-packet after five bits, then a fresh packet.
      start(5);
      cy(1, 0, 0, 1, J, 0, 0, 0);
      for (int i = 0; i < 4; i++) cy(1, 1, 0, 1, K, 1, 0, 0);
      rst = 1'b1;
      cy(0, 0, 0, 0, J, 0, 0, 0);
      rst = 1'b0;
      cy(1, 0, 0, 1, J, 0, 0, 0);
      cy(1, 1, 1, 1, K, 1, 0, 0);
      cy(0, 0, 0, 0, K, 1, 0, 0);
      eop_tail();

      // Back-to-back single-bit packets; second starts in the first IDLE cycle.
      start(6);
      cy(1, 1, 1, 1, J, 0, 0, 0);
      cy(0, 0, 0, 0, J, 1, 0, 0);
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(0, 0, 0, 0, S, 1, 0, 0);
      cy(1, 0, 1, 1, J, 1, 1, 0);
      cy(0, 0, 0, 0, K, 1, 0, 0);
      eop_tail();

      @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/usb_nrzi_tx.md
# usb_nrzi_tx

Transmit-side USB line encoder: takes a serial stream of raw packet bits, one per clock, and produces bit-stuffed, NRZI-encoded differential line states. It ends each packet with an EOP. It sits between the packet serializer and the pad driver and is the transmit counterpart of the receive-side NRZI decoder. The clock equals the bit rate. Line convention is full-speed: J = (dp=1, dm=0), K = (dp=0, dm=1), SE0 = (0,0).

## Interface
- STUFF_LEN, 6, number of consecutive 1s after which a 0 is stuffed
- EOP_SE0_CYCLES, 2, SE0 bit times in EOP
- clk  in  1  bit-rate clock
- rst  in  1  asynchronous, active-high reset
- bstr_in  in  1  raw data bit
- bstr_in_ready  in  1  bstr_in is valid
- in_done  in  1  qualifies the current bit as the last bit of the packet
- bstr_in_take  out  1  bit accepted this cycle when high together with bstr_in_ready (combinational from state)
- dp  out  1  registered D+ level
- dm  out  1  registered D- level
- tx_oe  out  1  registered pad output enable
- out_done  out  1  registered one-cycle pulse, coincident with the EOP J bit on the line
- tx_err  out  1  registered one-cycle pulse on underrun abort

One clock; reset is asynchronous and active-high; ports named clk and rst.

## Operation
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- Internal line-level register `lvl` holds the last NRZI level; it resets to J.
- Encoding on accept: bit 0 toggles `lvl`; bit 1 holds it. The driven (dp,dm) equals `lvl` in IDLE, DATA and STUFF, except that tx_oe=0 in IDLE.
- IDLE:
  - bstr_in_take=1.
  - A bit is accepted when bstr_in_ready=1, and the state goes to DATA (or STUFF, EOP_SE0 per the rules below).
- DATA:
  - bstr_in_take=1.
  - Accepting a 1 increments the ones counter (width clog2(STUFF_LEN+1)); accepting a 0 clears it.
  - If the counter reaches STUFF_LEN on this accept, next state is STUFF. This applies even when in_done=1; a pending stuff always precedes EOP.
  - Else, if in_done=1, next state is EOP_SE0.
- STUFF:
  - bstr_in_take=0.
  - Emits a 0 (toggles `lvl`) and clears the counter.
  - Next state is EOP_SE0 if the stuffed bit followed the last bit, else DATA.
- Underrun: in DATA with bstr_in_ready=0:
  - Pulse tx_err.
  - Go to EOP_SE0 (truncated packet).
  - Clear the counter.
- EOP_SE0:
  - bstr_in_take=0.
  - Drive SE0 for EOP_SE0_CYCLES cycles (down-counter).
  - Then go to EOP_J.
- EOP_J:
  - bstr_in_take=0.
  - Drive J; out_done=1.
  - `lvl` is set to J.
  - Next state is IDLE.

## Timing
- Reset values: dp=1, dm=0, tx_oe=0, out_done=0, tx_err=0, bstr_in_take=0 while rst is high, state=IDLE, counter=0.
- A bit accepted in cycle N appears on dp/dm in cycle N+1.
- tx_oe rises in N+1 for the first accepted bit. It falls in the cycle after the EOP J cycle.
- Stuff timing: after the STUFF_LEN-th 1 is accepted in cycle N, bstr_in_take=0 in N+1 and the stuffed bit appears on the line in N+2.
- EOP timing: after the last bit is accepted in N with no stuff, SE0 appears in N+2..N+1+EOP_SE0_CYCLES and J appears in N+2+EOP_SE0_CYCLES with out_done=1.
- Back-to-back packets: a new packet may be accepted in the first IDLE cycle.
- Asserting rst mid-packet forces all reset values immediately. No EOP is emitted and no done pulse is produced.
- in_done is ignored when bstr_in_ready=0.

## Configuration
- USB_NRZI_TX_STUFF_EN defined: bit stuffing as above.
- Not defined: the STUFF state and ones counter are absent, and bstr_in_take stays 1 throughout DATA. Latency and EOP are otherwise unchanged.

## Test plan
- SYNC: bits 0,0,0,0,0,0,0,1 (last on bit 8) from IDLE -> line K,J,K,J,K,J,K,K, then SE0,SE0, then J with out_done=1, then tx_oe=0.
- Stuffing: eight 1s preceded by one 0 -> K held for 7 cycles, J stuffed (bstr_in_take=0 for exactly one cycle after the sixth 1), then J,J.
- Stuff at end: six 1s with in_done on the sixth -> stuffed toggle precedes SE0; out_done lands 1 cycle later than the no-stuff case.
- Underrun: bstr_in_ready dropped after 3 bits with in_done=0 -> tx_err pulse, then SE0×2 and J.
- Reset mid-packet after 5 bits -> dp=1, dm=0, tx_oe=0 immediately; next packet encodes from J with the counter cleared.
- With USB_NRZI_TX_STUFF_EN undefined, eight 1s -> no stuffed bit, and bstr_in_take stays high.
